// File: rtl/cpu_clk_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_clk_ctrl_pkg
//   Shared definitions for the CPU clock-enable controller: the FSM state
//   encoding and the default debounce length (1,000,000 board-clock cycles).
// -----------------------------------------------------------------------------
package cpu_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_e;

  localparam int DBNC_CNT_DEF = 1000000;

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Two-flop synchronizer followed by a debouncer for one raw switch/button.
//   db flips on the DBNC_CNT-th consecutive clock edge at which the
//   synchronized input differs from db; any agreeing edge restarts the count.
//
//   Parameters: DBNC_CNT  stable cycles required before a change is accepted (>=1)
//   Ports:      clk  board clock
//               rst  synchronous, active-high reset
//               raw  asynchronous raw input
//               db   debounced, registered output
// -----------------------------------------------------------------------------
module btn_debounce
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DBNC_CNT = DBNC_CNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);

  // The count never needs to hold DBNC_CNT itself: the last disagreeing edge
  // flips db and restarts the count in one go.
  localparam int              CW       = (DBNC_CNT > 1) ? $clog2(DBNC_CNT) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DBNC_CNT - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: non-blocking assignments let every flop sample the pre-edge value
  // of its neighbour, which is what makes sync1_q -> sync2_q a real 2-stage chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clk_ctrl
//   Clock-enable controller for the pipelined CPU. Runs on the board clock and
//   issues one-cycle cpu_ce pulses either from a programmable prescaler (run
//   mode, one pulse every 2^div_sel cycles) or from a debounced push-button
//   (single-step mode), so the whole core stays in a single clock domain.
//
//   Parameters: DIV_W     prescaler width, div_sel in 0..DIV_W-1 (DIV_W >= 2)
//               DBNC_CNT  debounce length in clk cycles
//               CNT_W     width of the retired-cycle counter
//   Ports:      clk        board clock
//               rst        synchronous, active-high reset
//               run_sw     raw run switch (1 = free run)
//               step_btn   raw single-step push-button
//               div_sel    run-mode rate select
//               clr_cnt    synchronous clear of cycle_cnt (wins over increment)
//               cpu_ce     registered one-cycle clock enable to the CPU
//               running    registered, 1 while in RUN
//               cycle_cnt  number of cpu_ce pulses issued, wraps
//   Optional (macro CLK_CTRL_BREAK_EN):
//               pc, bp_addr, bp_valid  breakpoint compare inputs
//               bp_hit                 registered, sticky breakpoint flag
// -----------------------------------------------------------------------------
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DIV_W    = 32,
  parameter int DBNC_CNT = DBNC_CNT_DEF,
  parameter int CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run_sw,
  input  logic                     step_btn,
  input  logic [$clog2(DIV_W)-1:0] div_sel,
  input  logic                     clr_cnt,
`ifdef CLK_CTRL_BREAK_EN
  input  logic [31:0]              pc,
  input  logic [31:0]              bp_addr,
  input  logic                     bp_valid,
  output logic                     bp_hit,
`endif
  output logic                     cpu_ce,
  output logic                     running,
  output logic [CNT_W-1:0]         cycle_cnt
);

  logic run_db, step_db, step_db_q, step_edge;

  btn_debounce #(.DBNC_CNT(DBNC_CNT)) u_run_dbnc (
    .clk (clk),
    .rst (rst),
    .raw (run_sw),
    .db  (run_db)
  );

  btn_debounce #(.DBNC_CNT(DBNC_CNT)) u_step_dbnc (
    .clk (clk),
    .rst (rst),
    .raw (step_btn),
    .db  (step_db)
  );

  assign step_edge = step_db & ~step_db_q;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   pre_q, pre_d, div_max;
  logic               tick;
  logic               cpu_ce_q, cpu_ce_d;
  logic               running_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bp_break;    // breakpoint matched on a tick cycle in RUN
  logic               bp_blocked;  // sticky flag holding off HALT->RUN

  // >= rather than == so that lowering div_sel mid-count ticks on the next
  // cycle instead of wrapping the whole counter.
  assign div_max = (DIV_W'(1) << div_sel) - DIV_W'(1);
  assign tick    = (pre_q >= div_max);

`ifdef CLK_CTRL_BREAK_EN
  logic bp_hit_q, bp_hit_d;

  assign bp_break = (state_q == RUN) && tick && bp_valid && (pc == bp_addr);

  // A fresh hit wins over a clear in the same cycle so a breakpoint is never lost.
  always_comb begin
    bp_hit_d = bp_hit_q;
    if (bp_break) begin
      bp_hit_d = 1'b1;
    end else if (!run_db || step_edge) begin
      bp_hit_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_hit_q <= 1'b0;
    end else begin
      bp_hit_q <= bp_hit_d;
    end
  end

  assign bp_blocked = bp_hit_q;
  assign bp_hit     = bp_hit_q;
`else
  assign bp_break   = 1'b0;
  assign bp_blocked = 1'b0;
`endif

  // NOTE: every signal gets a default before the case/if tree so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HALT: begin
        // Run request takes priority; a simultaneous step edge is dropped.
        if (run_db && !bp_blocked) begin
          state_d = RUN;
        end else if (step_edge) begin
          state_d = STEP;
        end
      end
      RUN:     if (!run_db || bp_break) state_d = HALT;
      STEP:    state_d = HALT;
      default: state_d = HALT;
    endcase

    // Prescaler only advances in RUN and restarts from 0 on each entry.
    pre_d = pre_q;
    if (state_q != RUN && state_d == RUN) begin
      pre_d = '0;
    end else if (state_q == RUN) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end

    // cpu_ce is decoded from the current state and registered, so it trails
    // the state by one edge; requiring state_d == RUN suppresses any pulse
    // on the edge that leaves RUN (switch off or breakpoint).
    cpu_ce_d = (state_q == STEP) || (state_q == RUN && state_d == RUN && tick);

    cnt_d = clr_cnt ? '0 : cnt_q + CNT_W'(cpu_ce_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HALT;
      pre_q     <= '0;
      cpu_ce_q  <= 1'b0;
      running_q <= 1'b0;
      cnt_q     <= '0;
      step_db_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      cpu_ce_q  <= cpu_ce_d;
      running_q <= (state_d == RUN);
      cnt_q     <= cnt_d;
      step_db_q <= step_db;
    end
  end

  assign cpu_ce    = cpu_ce_q;
  assign running   = running_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_clk_ctrl
//   Self-checking bench for cpu_clk_ctrl (default build, no breakpoint ports).
//   A behavioural model (raw-sample history, debounce streaks, a mode enum and
//   an elapsed-cycle counter) is advanced at each clock edge and compared with
//   the DUT outputs 1 time unit later; directed steps add fixed expectations.
// -----------------------------------------------------------------------------
module tb_cpu_clk_ctrl;

  localparam int DIV_W = 8;
  localparam int DBNC  = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             run_sw;
  logic             step_btn;
  logic [2:0]       div_sel;
  logic             clr_cnt;
  logic             cpu_ce;
  logic             running;
  logic [CNT_W-1:0] cycle_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_clk_ctrl #(.DIV_W(DIV_W), .DBNC_CNT(DBNC), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .run_sw    (run_sw),
    .step_btn  (step_btn),
    .div_sel   (div_sel),
    .clr_cnt   (clr_cnt),
    .cpu_ce    (cpu_ce),
    .running   (running),
    .cycle_cnt (cycle_cnt)
  );

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_FREE, M_SINGLE} mode_e;
  typedef struct {
    bit h1;      // raw value taken at the previous edge
    bit h2;      // raw value taken two edges ago (= synchronizer output)
    bit db;      // accepted level
    int streak;  // consecutive edges the synchronized level disagreed with db
  } deb_t;

  deb_t  m_run, m_step;
  bit    m_step_prev;
  mode_e m_mode;
  int    m_elapsed;
  bit    m_ce;
  int    m_cnt;

  function automatic deb_t deb_next(deb_t d, bit raw);
    deb_t n;
    n = d;
    if (d.h2 != d.db) begin
      n.streak = d.streak + 1;
      if (n.streak == DBNC) begin
        n.db     = d.h2;
        n.streak = 0;
      end
    end else begin
      n.streak = 0;
    end
    n.h2 = d.h1;
    n.h1 = raw;
    return n;
  endfunction

  task automatic model_reset();
    m_run       = '{default: 0};
    m_step      = '{default: 0};
    m_step_prev = 1'b0;
    m_mode      = M_IDLE;
    m_elapsed   = 0;
    m_ce        = 1'b0;
    m_cnt       = 0;
  endtask

  task automatic model_edge();
    bit    st_edge;
    bit    tick;
    bit    nce;
    mode_e nm;
    if (rst) begin
      model_reset();
      return;
    end
    st_edge = m_step.db && !m_step_prev;
    tick    = (m_mode == M_FREE) && (m_elapsed >= (1 << div_sel) - 1);
    nm      = m_mode;
    case (m_mode)
      M_IDLE:  if (m_run.db) nm = M_FREE; else if (st_edge) nm = M_SINGLE;
      M_FREE:  if (!m_run.db) nm = M_IDLE;
      default: nm = M_IDLE;
    endcase
    nce   = (m_mode == M_SINGLE) || (tick && nm == M_FREE);
    m_cnt = clr_cnt ? 0 : (m_cnt + int'(m_ce)) % (1 << CNT_W);
    if (nm == M_FREE) m_elapsed = (m_mode != M_FREE || tick) ? 0 : m_elapsed + 1;
    m_step_prev = m_step.db;
    m_run       = deb_next(m_run, run_sw);
    m_step      = deb_next(m_step, step_btn);
    m_mode      = nm;
    m_ce        = nce;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("cpu_ce", 32'(cpu_ce), 32'(m_ce));
    check("running", 32'(running), 32'(m_mode == M_FREE));
    check("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first;
    int nce;
    int run_hold;
    int step_hold;

    rst = 1'b1; run_sw = 1'b0; step_btn = 1'b0; div_sel = 3'd0; clr_cnt = 1'b0;
    model_reset();
    cycles(2);
    check("reset_ce", 32'(cpu_ce), 32'd0);
    check("reset_running", 32'(running), 32'd0);
    check("reset_cnt", 32'(cycle_cnt), 32'd0);
    rst = 1'b0;
    cycles(3);

    // Short glitch on the step button is filtered out.
    step_btn = 1'b1; cycles(2);
    step_btn = 1'b0; cycles(12);
    check("glitch_cnt", 32'(cycle_cnt), 32'd0);

    // Held press: single pulse, set on edge DBNC+3 = 7.
    step_btn = 1'b1;
    first = -1; nce = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (cpu_ce) begin
        nce++;
        if (first < 0) first = k;
      end
    end
    check("step_latency", 32'(first), 32'd7);
    check("step_pulses", 32'(nce), 32'd1);
    check("step_cnt", 32'(cycle_cnt), 32'd1);

    // Release and press again: one more pulse.
    step_btn = 1'b0; cycles(10);
    step_btn = 1'b1; cycles(12);
    step_btn = 1'b0; cycles(10);
    check("step2_cnt", 32'(cycle_cnt), 32'd2);

    // Run mode at div_sel=2: one pulse per 4 cycles.
    div_sel = 3'd2; run_sw = 1'b1;
    cycles(8);
    nce = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      nce += int'(cpu_ce);
    end
    check("run_rate", 32'(nce), 32'd10);
    check("run_running", 32'(running), 32'd1);

    // Lower div_sel 3->0 while the prescaler holds 6: tick on the next cycle.
    div_sel = 3'd3;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (cpu_ce) break;
    end
    check("ce_seen", 32'(cpu_ce), 32'd1);
    cycles(6);
    div_sel = 3'd0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("fast_ce", 32'(cpu_ce), 32'd1);
    end

    // Step presses in RUN are ignored: div_sel=3 gives exactly 3 pulses in 24.
    div_sel = 3'd3; step_btn = 1'b1;
    nce = 0;
    for (int k = 0; k < 24; k++) begin
      cycle();
      nce += int'(cpu_ce);
      if (k == 11) step_btn = 1'b0;
    end
    check("run_ignores_step", 32'(nce), 32'd3);
    cycles(4);

    // Switch off: halts after the debounce delay, then no pulses.
    run_sw = 1'b0;
    cycles(10);
    check("halted", 32'(running), 32'd0);
    nce = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      nce += int'(cpu_ce);
    end
    check("halt_no_ce", 32'(nce), 32'd0);

    // Run and step debounce on the same edge: RUN wins, no step pulse.
    div_sel = 3'd2; run_sw = 1'b1; step_btn = 1'b1;
    nce = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      nce += int'(cpu_ce);
    end
    check("sim_no_step", 32'(nce), 32'd0);
    check("sim_running", 32'(running), 32'd1);
    step_btn = 1'b0;
    cycles(5);

    // Synchronous reset in the middle of RUN.
    rst = 1'b1;
    cycle();
    check("rst_mid_ce", 32'(cpu_ce), 32'd0);
    check("rst_mid_running", 32'(running), 32'd0);
    check("rst_mid_cnt", 32'(cycle_cnt), 32'd0);
    rst = 1'b0;

    // 16 pulses wrap the 4-bit counter back to 0.
    div_sel = 3'd0;
    nce = 0;
    for (int k = 0; k < 60 && nce < 16; k++) begin
      cycle();
      nce += int'(cpu_ce);
    end
    check("wrap_pulses", 32'(nce), 32'd16);
    cycle();
    check("wrap_cnt", 32'(cycle_cnt), 32'd0);

    // Clear during a pulse cycle gives 0, then counting resumes.
    cycles(3);
    clr_cnt = 1'b1;
    cycle();
    check("clr_cnt", 32'(cycle_cnt), 32'd0);
    clr_cnt = 1'b0;
    cycle();
    check("clr_then_inc", 32'(cycle_cnt), 32'd1);

    // Randomised phase against the model.
    run_hold = 0; step_hold = 0;
    for (int k = 0; k < 4000; k++) begin
      if (run_hold == 0) begin
        run_sw   = 1'($urandom_range(0, 1));
        run_hold = $urandom_range(1, 40);
      end else begin
        run_hold--;
      end
      if (step_hold == 0) begin
        step_btn  = 1'($urandom_range(0, 1));
        step_hold = $urandom_range(1, 12);
      end else begin
        step_hold--;
      end
      if ($urandom_range(0, 49) == 0) div_sel = 3'($urandom_range(0, 3));
      clr_cnt = ($urandom_range(0, 39) == 0);
      rst     = ($urandom_range(0, 699) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
